// File: rtl/var_mem_arbiter.sv
// var_mem_arbiter
//   Arbitrates the single-port local-variable BRAM between the execute stage
//   (port A, frame-relative local.get/set/tee) and the host/loader (port B,
//   absolute addresses). Owns the frame base/size registers, bounds-checks
//   port A, and returns registered responses with valid/ready backpressure.
//
// Optional build macro:
//   VARMEM_INIT_ZERO_EN - INIT sweeps the whole BRAM writing zeros before
//                         any request is accepted.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_frame_we/base/size          frame register load
//   a_req_* / a_rsp_*               port A request / response handshake
//   b_req_* / b_rsp_*               port B request / response handshake
//   mem_addr/we/wr_data/rd_data     BRAM interface (combinational read)
//   init_done                       memory usable
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_INIT | after reset; optional zero sweep runs here, no requests granted
// S_RUN  | normal arbitration between port A and port B
module var_mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_frame_we,
    input  logic [ADDR_WIDTH-1:0] cfg_frame_base,
    input  logic [ADDR_WIDTH:0]   cfg_frame_size,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_idx,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    output logic                  a_rsp_err,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  init_done
);

    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("DEPTH does not fit in ADDR_WIDTH");
    end

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] frame_base_q;
    logic [ADDR_WIDTH:0]   frame_size_q;
    logic                  rr_last_b_q;
    logic                  run_ok;
    logic                  elig_a, elig_b;
    logic                  grant_a, grant_b;
    logic                  a_err;
    logic [ADDR_WIDTH-1:0] a_addr;

`ifdef VARMEM_INIT_ZERO_EN
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = ADDR_WIDTH'(DEPTH - 1);
    logic [ADDR_WIDTH-1:0] sweep_q;
    logic                  sweep_done;

    assign sweep_done = (sweep_q == SWEEP_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            sweep_q <= '0;
        else if (state_q == S_INIT)
            sweep_q <= sweep_q + 1'b1;
    end
`endif

    assign init_done = (state_q == S_RUN);
    // Holding off grants while rst is high keeps a mid-operation reset from
    // committing a BRAM write at the resetting edge.
    assign run_ok    = init_done && !rst;
    assign elig_a    = run_ok && a_req_valid && (!a_rsp_valid || a_rsp_ready);
    assign elig_b    = run_ok && b_req_valid && (!b_rsp_valid || b_rsp_ready);

    // rr_last_b_q = 1 means B won the last grant, so A wins the next tie.
    assign grant_a   = elig_a && (!elig_b || rr_last_b_q);
    assign grant_b   = elig_b && !grant_a;

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    assign a_addr = frame_base_q + a_req_idx;
    assign a_err  = ({1'b0, a_req_idx} >= frame_size_q);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            S_INIT: begin
`ifdef VARMEM_INIT_ZERO_EN
                if (!rst) begin
                    mem_we   = 1'b1;
                    mem_addr = sweep_q;
                end
                if (sweep_done)
                    state_d = S_RUN;
`else
                state_d = S_RUN;
`endif
            end
            S_RUN: begin
                if (grant_a) begin
                    mem_addr    = a_addr;
                    mem_we      = a_req_we && !a_err;
                    mem_wr_data = a_req_wdata;
                end else if (grant_b) begin
                    mem_addr    = b_req_addr;
                    mem_we      = b_req_we;
                    mem_wr_data = b_req_wdata;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rsp_valid  <= 1'b0;
            a_rsp_data   <= '0;
            a_rsp_err    <= 1'b0;
            b_rsp_valid  <= 1'b0;
            b_rsp_data   <= '0;
            frame_base_q <= '0;
            frame_size_q <= '0;
            rr_last_b_q  <= 1'b1;
        end else begin
            if (grant_a) begin
                a_rsp_valid <= 1'b1;
                a_rsp_err   <= a_err;
                if (a_err)
                    a_rsp_data <= '0;
                else if (a_req_we)
                    a_rsp_data <= a_req_wdata;
                else
                    a_rsp_data <= mem_rd_data;
            end else if (a_rsp_ready) begin
                a_rsp_valid <= 1'b0;
            end

            if (grant_b) begin
                b_rsp_valid <= 1'b1;
                b_rsp_data  <= b_req_we ? b_req_wdata : mem_rd_data;
            end else if (b_rsp_ready) begin
                b_rsp_valid <= 1'b0;
            end

            if (grant_a)
                rr_last_b_q <= 1'b0;
            else if (grant_b)
                rr_last_b_q <= 1'b1;

            // A same-cycle port A grant above already used the old frame.
            if (cfg_frame_we) begin
                frame_base_q <= cfg_frame_base;
                frame_size_q <= cfg_frame_size;
            end
        end
    end

endmodule

// File: tb/tb_var_mem_arbiter.sv
// tb_var_mem_arbiter
//   Directed and random stimulus for var_mem_arbiter. A small BRAM harness
//   backs the DUT; a behavioural model (word array, frame, per-port pending
//   response, last-winner flag) predicts every cycle's grants, BRAM access
//   and responses.
module tb_var_mem_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
`ifdef VARMEM_INIT_ZERO_EN
    localparam bit SWEEP    = 1'b1;
    localparam int INIT_CYC = DEPTH;
`else
    localparam bit SWEEP    = 1'b0;
    localparam int INIT_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_frame_we;
    logic [AW-1:0] cfg_frame_base;
    logic [AW:0]   cfg_frame_size;
    logic          a_req_valid, a_req_ready, a_req_we;
    logic [AW-1:0] a_req_idx;
    logic [DW-1:0] a_req_wdata;
    logic          a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [DW-1:0] a_rsp_data;
    logic          b_req_valid, b_req_ready, b_req_we;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          init_done;

    logic [DW-1:0] bram [DEPTH];
    logic          mem_clr;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_av, m_bv, m_aerr, m_last_b;
    logic [DW-1:0] m_ad, m_bd;
    int            m_base, m_size, m_init_left;
    int            passed, total;

    always #5 clk = ~clk;

    var_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cfg_frame_we(cfg_frame_we), .cfg_frame_base(cfg_frame_base),
        .cfg_frame_size(cfg_frame_size),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_idx(a_req_idx), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .init_done(init_done)
    );

    assign mem_rd_data = bram[mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
        end else if (mem_we) begin
            bram[mem_addr] <= mem_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_idx = '0; a_req_wdata = '0;
        a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_rsp_ready = 1'b1;
        cfg_frame_we = 1'b0; cfg_frame_base = '0; cfg_frame_size = '0;
    endtask

    // Called #1 after a posedge with rst high; checks reset values and
    // resets the model.
    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        chk("rst_a_rsp_valid", 64'(a_rsp_valid), 64'(0));
        chk("rst_a_rsp_data",  64'(a_rsp_data),  64'(0));
        chk("rst_a_rsp_err",   64'(a_rsp_err),   64'(0));
        chk("rst_b_rsp_valid", 64'(b_rsp_valid), 64'(0));
        chk("rst_b_rsp_data",  64'(b_rsp_data),  64'(0));
        chk("rst_mem_we",      64'(mem_we),      64'(0));
        chk("rst_mem_addr",    64'(mem_addr),    64'(0));
        chk("rst_init_done",   64'(init_done),   64'(0));
        chk("rst_a_req_ready", 64'(a_req_ready), 64'(0));
        chk("rst_b_req_ready", 64'(b_req_ready), 64'(0));
        rst = 1'b0;
        m_av = 1'b0; m_bv = 1'b0; m_aerr = 1'b0; m_ad = '0; m_bd = '0;
        m_base = 0; m_size = 0; m_last_b = 1'b1; m_init_left = INIT_CYC;
    endtask

    // One clock cycle with the currently driven inputs: predict and check
    // the combinational grant/BRAM outputs, advance the model, then check
    // the registered responses after the edge.
    task automatic step();
        bit            m_init, ea, eb, ga, gb, aerr, exp_we;
        int            a_addr, exp_addr;
        logic [DW-1:0] exp_wd;
        #1;
        m_init = (m_init_left == 0);
        ea = m_init && a_req_valid && (!m_av || a_rsp_ready);
        eb = m_init && b_req_valid && (!m_bv || b_rsp_ready);
        ga = ea && (!eb || m_last_b);
        gb = eb && !ga;
        a_addr = (m_base + int'(a_req_idx)) % DEPTH;
        aerr   = (int'(a_req_idx) >= m_size);
        exp_we = 1'b0; exp_addr = 0; exp_wd = '0;
        if (!m_init) begin
            exp_we   = SWEEP;
            exp_addr = SWEEP ? (DEPTH - m_init_left) : 0;
        end else if (ga) begin
            exp_addr = a_addr; exp_we = a_req_we && !aerr; exp_wd = a_req_wdata;
        end else if (gb) begin
            exp_addr = int'(b_req_addr); exp_we = b_req_we; exp_wd = b_req_wdata;
        end
        chk("a_req_ready", 64'(a_req_ready), 64'(ga));
        chk("b_req_ready", 64'(b_req_ready), 64'(gb));
        chk("mem_addr",    64'(mem_addr),    64'(exp_addr));
        chk("mem_we",      64'(mem_we),      64'(exp_we));
        if (exp_we) chk("mem_wr_data", 64'(mem_wr_data), 64'(exp_wd));

        if (ga) begin
            m_av = 1'b1; m_aerr = aerr;
            if (aerr) m_ad = '0;
            else if (a_req_we) m_ad = a_req_wdata;
            else m_ad = m_mem[a_addr];
            if (a_req_we && !aerr) m_mem[a_addr] = a_req_wdata;
            m_last_b = 1'b0;
        end else if (a_rsp_ready) begin
            m_av = 1'b0;
        end
        if (gb) begin
            m_bv = 1'b1;
            m_bd = b_req_we ? b_req_wdata : m_mem[int'(b_req_addr)];
            if (b_req_we) m_mem[int'(b_req_addr)] = b_req_wdata;
            m_last_b = 1'b1;
        end else if (b_rsp_ready) begin
            m_bv = 1'b0;
        end
        if (cfg_frame_we) begin
            m_base = int'(cfg_frame_base);
            m_size = int'(cfg_frame_size);
        end
        if (!m_init) begin
            if (SWEEP) m_mem[DEPTH - m_init_left] = '0;
            m_init_left--;
        end

        @(posedge clk);
        #1;
        chk("a_rsp_valid", 64'(a_rsp_valid), 64'(m_av));
        chk("a_rsp_data",  64'(a_rsp_data),  64'(m_ad));
        chk("a_rsp_err",   64'(a_rsp_err),   64'(m_aerr));
        chk("b_rsp_valid", 64'(b_rsp_valid), 64'(m_bv));
        chk("b_rsp_data",  64'(b_rsp_data),  64'(m_bd));
        chk("init_done",   64'(init_done),   64'(m_init_left == 0));
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        mem_clr = 1'b1;
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        mem_clr = 1'b0;
        do_reset();
        for (int i = 0; i < INIT_CYC; i++) step();

        // unconfigured frame: every port A access errors
        idle(); a_req_valid = 1'b1; a_req_idx = 10'd0; step();

        // frame write then read: base 100, size 4, idx 2
        idle(); cfg_frame_we = 1'b1; cfg_frame_base = 10'd100; cfg_frame_size = 11'd4; step();
        idle(); a_req_valid = 1'b1; a_req_we = 1'b1; a_req_idx = 10'd2; a_req_wdata = 32'hDEAD; step();
        idle(); a_req_valid = 1'b1; a_req_idx = 10'd2; step();

        // bounds error at idx == size; base+4 must stay untouched
        idle(); a_req_valid = 1'b1; a_req_we = 1'b1; a_req_idx = 10'd4; a_req_wdata = 32'h1; step();
        idle(); b_req_valid = 1'b1; b_req_addr = 10'd104; step();

        // round robin with both ports valid
        idle(); a_req_valid = 1'b1; a_req_idx = 10'd2; b_req_valid = 1'b1; b_req_addr = 10'd102;
        repeat (4) step();

        // backpressure on port B while A keeps being served
        idle(); b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 10'd5; b_req_wdata = 32'd7; step();
        idle(); b_req_valid = 1'b1; b_req_addr = 10'd5; step();
        b_rsp_ready = 1'b0; a_req_valid = 1'b1; a_req_idx = 10'd1;
        repeat (3) step();
        b_rsp_ready = 1'b1; a_req_valid = 1'b0;
        step();
        step();

        // wrap-around: base 1020, idx 6 -> address 2
        idle(); cfg_frame_we = 1'b1; cfg_frame_base = 10'd1020; cfg_frame_size = 11'd8; step();
        idle(); a_req_valid = 1'b1; a_req_idx = 10'd6; step();

        // config load in the same cycle as a port A grant uses the old frame
        idle(); a_req_valid = 1'b1; a_req_we = 1'b1; a_req_idx = 10'd7; a_req_wdata = 32'h1234_5678;
        cfg_frame_we = 1'b1; cfg_frame_base = 10'd0; cfg_frame_size = 11'd2; step();
        idle(); a_req_valid = 1'b1; a_req_idx = 10'd7; step();

        // reset with a response pending drops it
        idle(); a_req_valid = 1'b1; a_req_idx = 10'd0; a_rsp_ready = 1'b0; step();
        do_reset();
        for (int i = 0; i < INIT_CYC; i++) step();

        // B write addr0, reset, read addr0 back
        idle(); b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 10'd0; b_req_wdata = 32'd5; step();
        do_reset();
        for (int i = 0; i < INIT_CYC; i++) step();
        idle(); b_req_valid = 1'b1; b_req_addr = 10'd0; step();
        idle(); step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            a_req_valid    = ($urandom_range(0, 3) != 0);
            a_req_we       = ($urandom_range(0, 1) != 0);
            a_req_idx      = 10'($urandom_range(0, 15));
            a_req_wdata    = $urandom();
            a_rsp_ready    = ($urandom_range(0, 3) != 0);
            b_req_valid    = ($urandom_range(0, 2) != 0);
            b_req_we       = ($urandom_range(0, 1) != 0);
            b_req_addr     = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1016, 1023))
                                                         : 10'($urandom_range(0, 31));
            b_req_wdata    = $urandom();
            b_rsp_ready    = ($urandom_range(0, 3) != 0);
            cfg_frame_we   = ($urandom_range(0, 15) == 0);
            cfg_frame_base = ($urandom_range(0, 3) == 0) ? 10'd1018 : 10'($urandom_range(0, 20));
            cfg_frame_size = 11'($urandom_range(0, 12));
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/var_mem_arbiter.md
Name: var_mem_arbiter

Overview:
- Arbitrates the single-port local-variable BRAM between two requesters.
  - Port A: execute stage issuing local.get / local.set / local.tee by frame-relative index.
  - Port B: host/loader, absolute addresses.
- Owns the frame base/size registers and bounds-checks port A.
- Returns registered responses with valid/ready backpressure.
- Drives the BRAM's shared addr/we/wr_data. BRAM read is combinational and its write is synchronous.

Parameters:
- ADDR_WIDTH, 10 (= `log2_bram_depth_in), BRAM address width.
- DATA_WIDTH, 32 (= `bram_in_width), word width.
- DEPTH, 1024 (= `bram_depth_in), BRAM entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_frame_we  in  1  load frame registers.
- cfg_frame_base  in  ADDR_WIDTH  frame base address.
- cfg_frame_size  in  ADDR_WIDTH+1  number of locals in the frame.
- a_req_valid / a_req_ready  in / out  1  port A request handshake.
- a_req_we  in  1  1 = write (set/tee), 0 = read (get).
- a_req_idx  in  ADDR_WIDTH  local index.
- a_req_wdata  in  DATA_WIDTH  write data.
- a_rsp_valid / a_rsp_ready  out / in  1  port A response handshake.
- a_rsp_data  out  DATA_WIDTH  read data, or echoed write data.
- a_rsp_err  out  1  index out of frame.
- b_req_valid / b_req_ready  in / out  1  port B request handshake.
- b_req_we  in  1  port B write enable.
- b_req_addr  in  ADDR_WIDTH  absolute address.
- b_req_wdata  in  DATA_WIDTH  port B write data.
- b_rsp_valid / b_rsp_ready  out / in  1  port B response handshake.
- b_rsp_data  out  DATA_WIDTH  port B response data.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_we  out  1  BRAM write enable.
- mem_wr_data  out  DATA_WIDTH  BRAM write data.
- mem_rd_data  in  DATA_WIDTH  BRAM combinational read data.
- init_done  out  1  memory usable.

Behaviour:
- Reset values:
  - a_rsp_valid = b_rsp_valid = 0, a_rsp_data = b_rsp_data = 0, a_rsp_err = 0.
  - frame_base = 0, frame_size = 0, so every port A access errors until the frame is configured.
  - Round-robin pointer = B, so A wins the first tie.
  - mem_we = 0, mem_addr = 0.
- States: INIT, RUN. Reset enters INIT. Without the optional feature, INIT lasts exactly 1 cycle; init_done = (state == RUN).
- Eligibility: port X is eligible when init_done && X_req_valid && (!X_rsp_valid || X_rsp_ready).
  - This allows one outstanding response per port and full throughput when rsp_ready is held high.
- Grant: at most one per cycle.
  - Only one eligible port: that port is granted.
  - Both eligible: grant the port not granted last. The pointer updates only on a grant.
- X_req_ready = grant_X, combinational. The transfer happens in that same cycle.
- Granted cycle, mem_addr:
  - Port B: b_req_addr.
  - Port A: (frame_base + a_req_idx), truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
- Granted cycle, mem_we and mem_wr_data:
  - mem_we = req_we && !err.
  - mem_wr_data = req_wdata.
- No grant: mem_we = 0, mem_addr = 0.
- Port A bounds: err = (a_req_idx >= frame_size), compared unsigned at ADDR_WIDTH+1 bits. On err, memory is untouched.
- Response latency: 1 cycle. At the grant edge, X_rsp_valid <= 1 and X_rsp_data is captured as:
  - Read: mem_rd_data.
  - Write: req_wdata (tee echo).
  - Error: 0, with a_rsp_err = 1. Otherwise a_rsp_err = 0.
- X_rsp_valid clears on X_rsp_ready when no new grant occurs that cycle. Response data is held stable while valid && !ready.
- Read-after-write to the same address on back-to-back grants returns the new value. The write commits at the first edge; the read is combinational in the next cycle.
- cfg_frame_we loads base and size at the edge. A port A grant in the same cycle uses the old values.
- rst mid-operation returns all state to reset values. A response in flight is dropped, not delivered.

Optional Feature:
- Macro: VARMEM_INIT_ZERO_EN.
- Defined: INIT runs a sweep counter 0..DEPTH-1, writing 0 with mem_we = 1 for DEPTH cycles.
  - req_ready = 0 for the whole sweep.
  - init_done rises on the cycle after the last write, i.e. DEPTH+1 cycles after rst deasserts.
  - Reset during the sweep restarts it from 0.
- Undefined: no sweep; init_done = 1 from the second cycle after reset.

Test Plan:
- Frame write then read:
  - Stimulus: cfg base=100, size=4; A write idx2=0xDEAD; then A read idx2.
  - Response: mem_addr=102 with mem_we=1; read a_rsp_data=0xDEAD, err=0.
- Bounds error:
  - Stimulus: size=4; A write idx4=0x1.
  - Response: mem_we stays 0; a_rsp_err=1, a_rsp_data=0; the entry at base+4 is unchanged.
- Round-robin:
  - Stimulus: A and B both valid for 4 cycles, rsp_ready=1.
  - Response: grants A,B,A,B; each rsp_valid follows its grant by 1 cycle.
- Backpressure:
  - Stimulus: B read addr5 (=7), b_rsp_ready=0 for 3 cycles while B stays valid.
  - Response: b_req_ready=0 during the stall; b_rsp_data=7 held stable; A is still served meanwhile.
- Wrap-around:
  - Stimulus: base=1020, size=8 (DEPTH 1024); A read idx6.
  - Response: mem_addr=2.
- VARMEM_INIT_ZERO_EN defined:
  - Stimulus: B write addr0=5, reset, wait for init_done, B read addr0.
  - Response: init_done at cycle 1025; read returns 0.
